// File: rtl/load_store_aligner.sv
`default_nettype none
// ============================================================================
// Module   : load_store_aligner
// Purpose  : Sequential load/store unit that sits between the register file
//            and data memory. It performs byte, halfword and word accesses
//            over a DATA_W-bit memory. Sub-word stores are read-modify-write
//            operations. Loads sign-extend the addressed lanes. The control
//            unit sequences it with a start/done handshake.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            start_i          - request strobe (sampled only when idle)
//            op_i             - 000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB
//            addr_i           - byte address
//            wdata_i          - store source data
//            busy_o           - transaction in progress (through done cycle)
//            done_o           - one-cycle completion pulse
//            err_o            - misaligned/illegal request, valid with done
//            load_data_o      - sign-extended load result (held until next load)
//            mem_addr_o       - word-aligned memory address
//            mem_re_o         - memory read request
//            mem_we_o         - memory write strobe
//            mem_wdata_o      - memory write data
//            mem_rdata_i      - memory read data
// Revision : 1.0 - initial release
// ============================================================================
module load_store_aligner #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    localparam logic [2:0] OP_SW = 3'b100;
    localparam logic [1:0] SZ_W  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_B  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [15:0]        wsrc_q, wsrc_d;     // only the low 16 bits feed a merge
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_re_q, mem_re_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  load_data_q, load_data_d;

    // ------------------------------------------------------------------------
    // Request decode (evaluated on the raw inputs, used only in IDLE)
    // ------------------------------------------------------------------------
    logic              w_in_illegal;
    logic              w_in_misalign;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_in_illegal  = (op_i[1:0] == 2'b11);
    assign w_in_misalign = ((op_i[1:0] == SZ_H) && addr_i[0]) ||
                           ((op_i[1:0] == SZ_W) && (|addr_i[OFF_W-1:0]));
    assign w_word_addr   = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // ------------------------------------------------------------------------
    // Lane datapath on the latched request
    // ------------------------------------------------------------------------
    logic [OFF_W+2:0]  w_shamt;
    logic [DATA_W-1:0] w_rd_shifted;
    logic [DATA_W-1:0] w_load_ext;
    logic [DATA_W-1:0] w_lane_mask;
    logic [DATA_W-1:0] w_lane_data;
    logic [DATA_W-1:0] w_merged;

    assign w_shamt      = {off_q, 3'b000};
    assign w_rd_shifted = mem_rdata_i >> w_shamt;

    // Addressed lanes are shifted down to bit 0, then sign-extended.
    always_comb begin
        w_load_ext = w_rd_shifted;
        case (op_q[1:0])
            SZ_H: begin
                w_load_ext       = {DATA_W{w_rd_shifted[15]}};
                w_load_ext[15:0] = w_rd_shifted[15:0];
            end
            SZ_B: begin
                w_load_ext      = {DATA_W{w_rd_shifted[7]}};
                w_load_ext[7:0] = w_rd_shifted[7:0];
            end
            default: w_load_ext = w_rd_shifted;
        endcase
    end

    // Store lanes are built at bit 0 and moved up to the addressed offset.
    always_comb begin
        w_lane_mask = '0;
        w_lane_data = '0;
        if (op_q[1:0] == SZ_H) begin
            w_lane_mask[15:0] = '1;
            w_lane_data[15:0] = wsrc_q;
        end else begin
            w_lane_mask[7:0]  = '1;
            w_lane_data[7:0]  = wsrc_q[7:0];
        end
    end

    assign w_merged = (mem_rdata_i & ~(w_lane_mask << w_shamt)) |
                      (w_lane_data << w_shamt);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        wsrc_d      = wsrc_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    op_d   = op_i;
                    off_d  = addr_i[OFF_W-1:0];
                    wsrc_d = wdata_i[15:0];
                    busy_d = 1'b1;
                    if (w_in_illegal || w_in_misalign) begin
                        // Rejected without touching memory.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        mem_addr_d = w_word_addr;
                        if (op_i == OP_SW) begin
                            state_d     = ST_WRITE;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = wdata_i;
                        end else begin
                            state_d  = ST_READ;
                            mem_re_d = 1'b1;
                            cnt_d    = LAT_INIT;
                        end
                    end
                end
            end

            ST_READ: begin
                if (cnt_q == '0) begin
                    // Final read cycle: mem_rdata_i is valid on this edge.
                    if (op_q[2]) begin
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = w_merged;
                    end else begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        load_data_d = w_load_ext;
                    end
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    mem_re_d = 1'b1;
                end
            end

            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            wsrc_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            wsrc_q      <= wsrc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign load_data_o = load_data_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_re_o    = mem_re_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_aligner
// Purpose  : Scoreboard testbench for load_store_aligner (DATA_W=32,
//            MEM_LAT=1) with a latency-accurate memory model and a byte-level
//            reference model of loads and stores.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_aligner;

    localparam int MEM_LAT = 1;

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_LH = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SW = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;
    localparam logic [2:0] OP_SB = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, mem_re, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    load_store_aligner #(
        .DATA_W (32),
        .ADDR_W (32),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .op_i       (op),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .load_data_o(load_data),
        .mem_addr_o (mem_addr),
        .mem_re_o   (mem_re),
        .mem_we_o   (mem_we),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Memory environment: words in three 64-byte windows at 0x1000/0x2000/0x3000
    // ------------------------------------------------------------------------
    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];
    int          re_cnt;

    function automatic int idx(input logic [31:0] a);
        return int'(((a >> 12) & 32'd3) * 32'd16 + ((a >> 2) & 32'd15));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_cnt <= 0;
        end else begin
            re_cnt <= mem_re ? re_cnt + 1 : 0;
            if (mem_we) env_mem[idx(mem_addr)] <= mem_wdata;
        end
    end

    // Read data is only valid once the address has been held MEM_LAT cycles.
    always @(negedge clk) begin
        mem_rdata = (mem_re && re_cnt >= MEM_LAT) ? env_mem[idx(mem_addr)] : $urandom;
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          n_re;
        int          n_we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    exp_t        exp_q[$];
    chk_t        chk_q[$];
    logic [31:0] ref_ld = '0;
    int          push_cnt = 0;
    int          done_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t        e;
        int          size, off;
        logic [7:0]  b [4];
        logic [31:0] w;
        longint      v;
        off     = int'(a % 4);
        size    = (o[1:0] == 2'b00) ? 4 : (o[1:0] == 2'b01) ? 2 : 1;
        e.err   = (o[1:0] == 2'b11) || ((a % size) != 0);
        e.waddr = a & ~32'd3;
        e.n_re  = 0;
        e.n_we  = 0;
        e.wdata = '0;
        e.acc   = 0;
        e.lat   = 1;
        if (!e.err) begin
            w = ref_mem[idx(a)];
            for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
            if (!o[2]) begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(b[off+i]) << (8 * i);
                if (v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
                ref_ld = v[31:0];
                e.n_re = MEM_LAT + 1;
                e.lat  = MEM_LAT + 2;
            end else begin
                for (int i = 0; i < size; i++) b[off+i] = d[8*i +: 8];
                w = {b[3], b[2], b[1], b[0]};
                ref_mem[idx(a)] = w;
                e.n_we  = 1;
                e.wdata = w;
                e.n_re  = (size == 4) ? 0 : MEM_LAT + 1;
                e.lat   = (size == 4) ? 2 : MEM_LAT + 3;
            end
        end
        e.ld = ref_ld;
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] x);
        n_tests++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, a, x, $time);
        end
    endtask

    int          n_re, n_we, n_busy, we_cyc;
    logic [31:0] we_addr, we_data;
    bit          ovl, addr_bad, stray_err;

    always @(negedge clk) begin
        chk_t c;
        exp_t e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (!rst_n) begin
            n_re = 0; n_we = 0; n_busy = 0; we_cyc = 0;
            ovl = 0; addr_bad = 0; stray_err = 0;
        end else begin
            if (mem_re && mem_we) ovl = 1;
            if (err && !done) stray_err = 1;
            if (busy) n_busy++;
            if (mem_re) begin
                n_re++;
                if (exp_q.size() == 0) addr_bad = 1;
                else if (mem_addr !== exp_q[0].waddr) addr_bad = 1;
            end
            if (mem_we) begin
                n_we++;
                we_addr = mem_addr;
                we_data = mem_wdata;
                we_cyc  = (exp_q.size() > 0) ? cyc - exp_q[0].acc + 1 : -1;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    done_cnt++;
                    cmp("err", err, e.err);
                    cmp("load_data", load_data, e.ld);
                    cmp("read_cycles", n_re, e.n_re);
                    cmp("write_pulses", n_we, e.n_we);
                    if (e.n_we == 1) begin
                        cmp("write_addr", we_addr, e.waddr);
                        cmp("write_data", we_data, e.wdata);
                        cmp("write_cycle", we_cyc, e.lat - 1);
                    end
                    cmp("done_cycle", cyc - e.acc + 1, e.lat);
                    cmp("busy_cycles", n_busy, e.lat);
                    cmp("re_we_overlap", ovl, 0);
                    cmp("read_addr", addr_bad, 0);
                    cmp("err_outside_done", stray_err, 0);
                end
                n_re = 0; n_we = 0; n_busy = 0; we_cyc = 0;
                ovl = 0; addr_bad = 0; stray_err = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic post(input string nm, input logic [63:0] a, input logic [63:0] x);
        chk_t c;
        c.name = nm; c.act = a; c.exp = x;
        chk_q.push_back(c);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        env_mem[idx(a)] <= v;
        ref_mem[idx(a)] = v;
    endtask

    task automatic post_reset_outputs(input string tag);
        post({tag, "_busy"}, busy, 0);
        post({tag, "_done"}, done, 0);
        post({tag, "_err"}, err, 0);
        post({tag, "_mem_re"}, mem_re, 0);
        post({tag, "_mem_we"}, mem_we, 0);
        post({tag, "_mem_addr"}, mem_addr, 0);
        post({tag, "_mem_wdata"}, mem_wdata, 0);
        post({tag, "_load_data"}, load_data, 0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] d, input bit pulse);
        exp_t e;
        bit   seen;
        e = model(o, a, d);
        @(negedge clk);
        start = 1'b1; op = o; addr = a; wdata = d;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        push_cnt++;
        @(negedge clk);
        // Inputs change after acceptance; the DUT must use the latched copy.
        start = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            start = pulse && (k == 0);
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) post("done_timeout", 0, 1);
    endtask

    function automatic logic [2:0] rand_op();
        int r;
        r = $urandom_range(0, 19);
        if (r >= 18) return (r == 18) ? 3'b011 : 3'b111;
        case (r % 6)
            0: return OP_LW;
            1: return OP_LH;
            2: return OP_LB;
            3: return OP_SW;
            4: return OP_SH;
            default: return OP_SB;
        endcase
    endfunction

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        bit          we_seen;

        rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 64; i++) preload(32'h1000 + 32'(i * 4), $urandom);
        #3;
        post_reset_outputs("init_rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        preload(32'h1000, 32'h11223344);
        do_op(OP_SB, 32'h1003, 32'hAABBCCDD, 0);
        preload(32'h2000, 32'h11223344);
        do_op(OP_SH, 32'h2002, 32'h1234BEEF, 0);
        do_op(OP_SW, 32'h3000, 32'hCAFEF00D, 0);
        preload(32'h1000, 32'h11228044);
        do_op(OP_LB, 32'h1001, 32'h0, 0);
        preload(32'h1000, 32'h7FFF1234);
        do_op(OP_LH, 32'h1002, 32'h0, 0);
        do_op(OP_SW, 32'h1004, 32'h87654321, 0);
        do_op(OP_SH, 32'h2001, 32'h5555AAAA, 0);
        do_op(OP_LW, 32'h3002, 32'h0, 0);
        do_op(3'b111, 32'h1000, 32'h0, 0);
        do_op(OP_SB, 32'h1005, 32'h000000A5, 1);
        do_op(OP_LW, 32'h1004, 32'h0, 1);

        // Reset in cycle 1 of an SB aborts it without a write or done.
        preload(32'h1010, 32'h55667788);
        @(negedge clk);
        start = 1'b1; op = OP_SB; addr = 32'h1013; wdata = 32'h000000EE;
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1 post_reset_outputs("abort_rst");
        ref_ld = '0;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        we_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_we || done) we_seen = 1;
        end
        post("abort_no_activity", we_seen, 0);
        post("abort_mem_intact", env_mem[idx(32'h1010)], ref_mem[idx(32'h1010)]);
        do_op(OP_SB, 32'h1013, 32'h000000EE, 0);
        do_op(OP_LW, 32'h1010, 32'h0, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            o = rand_op();
            a = 32'h1000 + 32'($urandom_range(0, 63));
            if (o[1:0] == 2'b00 && $urandom_range(0, 3) != 0) a = a & ~32'd3;
            if (o[1:0] == 2'b01 && $urandom_range(0, 3) != 0) a = a & ~32'd1;
            do_op(o, a, $urandom, $urandom_range(0, 2) == 0);
            // A start in the DONE cycle must be ignored.
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b1; op = rand_op(); addr = $urandom; wdata = $urandom;
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                start = 1'b0;
            end
        end

        repeat (6) @(negedge clk);
        post("txn_count", done_cnt, push_cnt);
        post("queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
